logic_op_sequencer: RTL and testbench

//  Front-end driver for logic_unit. Collects two WIDTH-bit operands over a valid/ready stream and packs them as {op1,op2}.

---
 rtl/logic_pkg.sv | 17 +
 rtl/logic_unit.sv | 32 +++
 rtl/logic_op_sequencer.sv | 104 ++++++++++
 tb/tb_logic_op_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared encodings for the logic_unit front-end: sequencer FSM states and the
// select-line codes that logic_unit decodes.
package logic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OP2 = 2'd1,
        EXEC     = 2'd2,
        RESP     = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_NOT = 2'b11;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise unit fed with the packed word {op1,op2}.
// Upper half carries op1 <sel> op2 (NOT inverts op1), lower half its complement.
module logic_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] logic_in,
    input  logic [1:0]         logic_lines,
    output logic [2*WIDTH-1:0] logic_out
);

    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH-1:0] w_res;

    assign w_op1 = logic_in[2*WIDTH-1:WIDTH];
    assign w_op2 = logic_in[WIDTH-1:0];

    always_comb begin
        w_res = '0;
        case (logic_lines)
            SEL_AND: w_res = w_op1 & w_op2;
            SEL_OR:  w_res = w_op1 | w_op2;
            SEL_XOR: w_res = w_op1 ^ w_op2;
            default: w_res = ~w_op1;
        endcase
    end

    assign logic_out = {w_res, ~w_res};

endmodule

// File: rtl/logic_op_sequencer.sv
// Collects op1/op2 beats, presents {op1,op2} and the select to logic_unit,
// captures its output and returns it over a valid/ready result port.
module logic_op_sequencer
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [2*WIDTH-1:0] lu_in,
    output logic [1:0]         lu_lines,
    input  logic [2*WIDTH-1:0] lu_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic [1:0]         res_sel,
    output logic [CNT_W-1:0]   op_count
);

    seq_state_t           r_state;
    logic                 r_in_ready;
    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_lu_in;
    logic [1:0]           r_lu_lines;
    logic [2*WIDTH-1:0]   r_res_data;
    logic [1:0]           r_res_sel;
    logic [CNT_W-1:0]     r_op_count;

    logic                 w_in_beat;
    logic                 w_res_take;

    // in_ready is a register, so a beat never depends on a combinational loop.
    assign w_in_beat  = in_valid & r_in_ready;
    assign w_res_take = r_res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_lu_in     <= '0;
            r_lu_lines  <= '0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
            r_op_count  <= '0;
        end else if (clear) begin
            // Abort: operand/select lines stay put so logic_unit sees no glitch.
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_beat) begin
                        r_lu_in[2*WIDTH-1:WIDTH] <= in_data;
                        r_state                  <= WAIT_OP2;
                    end
                end
                WAIT_OP2: begin
                    if (w_in_beat) begin
                        r_lu_in[WIDTH-1:0] <= in_data;
                        r_lu_lines         <= in_sel;
                        r_in_ready         <= 1'b0;
                        r_state            <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_data  <= lu_out;
                    r_res_sel   <= r_lu_lines;
                    r_res_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_res_take) begin
                        r_op_count  <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign lu_in     = r_lu_in;
    assign lu_lines  = r_lu_lines;
    assign res_data  = r_res_data;
    assign res_sel   = r_res_sel;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer driving a logic_unit, plus a CNT_W=2 twin for wrap.
module tb_logic_op_sequencer;
    import logic_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        res_ready;

    logic        in_ready,  in_ready_w;
    logic [31:0] lu_in,     lu_in_w;
    logic [1:0]  lu_lines,  lu_lines_w;
    logic [31:0] lu_out,    lu_out_w;
    logic        res_valid, res_valid_w;
    logic [31:0] res_data,  res_data_w;
    logic [1:0]  res_sel,   res_sel_w;
    logic [7:0]  op_count;
    logic [1:0]  op_count_w;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic [31:0] last_lu = '0;

    logic_op_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .lu_in(lu_in), .lu_lines(lu_lines), .lu_out(lu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sel(res_sel), .op_count(op_count)
    );
    logic_unit #(.WIDTH(16)) lu (
        .logic_in(lu_in), .logic_lines(lu_lines), .logic_out(lu_out)
    );

    logic_op_sequencer #(.WIDTH(16), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_sel(in_sel),
        .lu_in(lu_in_w), .lu_lines(lu_lines_w), .lu_out(lu_out_w),
        .res_valid(res_valid_w), .res_ready(res_ready), .res_data(res_data_w),
        .res_sel(res_sel_w), .op_count(op_count_w)
    );
    logic_unit #(.WIDTH(16)) lu_w (
        .logic_in(lu_in_w), .logic_lines(lu_lines_w), .logic_out(lu_out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [1:0]  sel;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] golden(logic [15:0] a, logic [15:0] b, logic [1:0] s);
        logic [15:0] r;
        case (s)
            SEL_AND: r = a & b;
            SEL_OR:  r = a | b;
            SEL_XOR: r = a ^ b;
            default: r = ~a;
        endcase
        return {r, ~r};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; res_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hA5A5; in_sel = SEL_OR;
        tick();
        tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_lu_in", lu_in, 0);
        chk("rst_res_data", res_data, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        exp_count = 0;
        last_lu = '0;
        chk("rst_in_ready", in_ready, 1);
    endtask

    task automatic do_op(logic [15:0] a, logic [15:0] b, logic [1:0] s,
                         logic [31:0] exp, int stall, bit hold_valid);
        chk("op_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = a; in_sel = ~s;
        tick();
        chk("op1_latched", lu_in[31:16], a);
        chk("op1_ready", in_ready, 1);
        in_data = b; in_sel = s;
        tick();
        in_valid = hold_valid; in_data = 16'h5A5A;
        chk("op2_ready_low", in_ready, 0);
        chk("op2_no_valid_yet", res_valid, 0);
        chk("op2_lu_in", lu_in, {a, b});
        chk("op2_lu_lines", lu_lines, s);
        tick();
        chk("res_valid_latency", res_valid, 1);
        chk("res_data", res_data, exp);
        chk("res_sel", res_sel, s);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("bp_ready_low", in_ready, 0);
            chk("bp_valid_held", res_valid, 1);
            chk("bp_data_stable", res_data, exp);
            chk("bp_count_held", op_count, exp_count[7:0]);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        in_valid = 1'b0;
        exp_count++;
        last_lu = {a, b};
        chk("done_count", op_count, exp_count[7:0]);
        chk("done_valid_low", res_valid, 0);
        chk("done_ready", in_ready, 1);
    endtask

    task automatic run_random(int n, bit rnd);
        logic [31:0] q_res[$];
        logic [1:0]  q_sel[$];
        logic [15:0] op1_h;
        logic [31:0] exp_r;
        logic [1:0]  exp_s;
        int beats = 0;
        int done = 0;
        int pend = 0;
        int cyc = 0;
        op1_h = '0;
        while (done < n && cyc < 3000) begin
            chk("rnd_in_ready", in_ready, (pend == 0) ? 1 : 0);
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = 16'($urandom);
            in_sel    = 2'($urandom_range(0, 3));
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                if (beats % 2 == 0) begin
                    op1_h = in_data;
                end else begin
                    q_res.push_back(golden(op1_h, in_data, in_sel));
                    q_sel.push_back(in_sel);
                    pend++;
                end
                beats++;
            end
            if (res_valid && res_ready) begin
                if (q_res.size() == 0) begin
                    chk("rnd_spurious_result", 1, 0);
                end else begin
                    exp_r = q_res.pop_front();
                    exp_s = q_sel.pop_front();
                    chk("rnd_res_data", res_data, exp_r);
                    chk("rnd_res_sel", res_sel, exp_s);
                    done++;
                    pend--;
                    exp_count++;
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        chk("rnd_ops_done", done, n);
        chk("rnd_op_count", op_count, exp_count[7:0]);
    endtask

    initial begin
        logic [15:0] a, b;
        logic [1:0]  s;
        int wrap_exp[5];

        vecs[0] = '{16'hF0F0, 16'h0FF0, SEL_XOR, 32'hFF0000FF};
        vecs[1] = '{16'hF0F0, 16'h0FF0, SEL_AND, 32'h00F0FF0F};
        vecs[2] = '{16'hF0F0, 16'h0FF0, SEL_OR,  32'hFFF0000F};
        vecs[3] = '{16'h1234, 16'hFFFF, SEL_NOT, 32'hEDCB1234};
        vecs[4] = '{16'hFFFF, 16'hFFFF, SEL_AND, 32'hFFFF0000};
        vecs[5] = '{16'h0000, 16'h0000, SEL_OR,  32'h0000FFFF};
        wrap_exp = '{1, 2, 3, 0, 1};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; in_sel = '0; res_ready = 1'b0;

        do_reset();

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].op1, vecs[i].op2, vecs[i].sel, vecs[i].exp_res, 0, 1'b0);

        // Backpressure with in_valid held high throughout RESP.
        do_op(16'hC3C3, 16'h3C3C, SEL_XOR, 32'hFFFF0000, 5, 1'b1);

        // Clear while waiting for op2.
        in_valid = 1'b1; in_data = 16'h1111; in_sel = SEL_AND;
        tick();
        clear = 1'b1; in_data = 16'h2222;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr1_ready", in_ready, 1);
        chk("clr1_lu_in", lu_in, {16'h1111, last_lu[15:0]});
        chk("clr1_count", op_count, exp_count[7:0]);
        in_valid = 1'b1; in_data = 16'h3333;
        tick();
        in_valid = 1'b0;
        chk("clr1_next_is_op1", lu_in, {16'h3333, last_lu[15:0]});
        in_valid = 1'b1; in_data = 16'h4444; in_sel = SEL_OR;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr1_res", res_data, golden(16'h3333, 16'h4444, SEL_OR));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_count++;
        chk("clr1_done_count", op_count, exp_count[7:0]);

        // Clear while a result is pending, with a competing handshake and beat.
        in_valid = 1'b1; in_data = 16'h5555;
        tick();
        in_data = 16'h6666; in_sel = SEL_AND;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr2_in_resp", res_valid, 1);
        clear = 1'b1; res_ready = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
        tick();
        clear = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
        chk("clr2_valid_drop", res_valid, 0);
        chk("clr2_count_held", op_count, exp_count[7:0]);
        chk("clr2_ready", in_ready, 1);
        chk("clr2_lu_in_kept", lu_in, {16'h5555, 16'h6666});
        chk("clr2_lines_kept", lu_lines, SEL_AND);
        last_lu = {16'h5555, 16'h6666};
        do_op(16'h8888, 16'h0F0F, SEL_XOR, golden(16'h8888, 16'h0F0F, SEL_XOR), 0, 1'b0);

        // Back-to-back random ops, then random valid/ready gaps.
        do_reset();
        run_random(20, 1'b0);
        chk("b2b_count_20", op_count, 20);
        run_random(15, 1'b1);

        // Counter wrap on the CNT_W=2 twin.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 2'($urandom_range(0, 3));
            do_op(a, b, s, golden(a, b, s), 0, 1'b0);
            chk("wrap_count", op_count_w, wrap_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
